// File: rtl/led_matrix_scanner_pkg.sv
// led_matrix_pkg: shared defaults, row index type and one-hot row helper for the matrix scanner
package led_matrix_pkg;
  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;
  localparam int DIV_W_DEF = 14;
  localparam int BRIGHT_W_DEF = 4;
  localparam int BLANK_DEF = 64;
  localparam int MAX_ROWS = 32;
  localparam int ROW_IDX_W = 5;
  typedef logic [$clog2(ROWS_DEF)-1:0] row_idx_t;
  function automatic logic [MAX_ROWS-1:0] one_hot_row(input logic [ROW_IDX_W-1:0] idx);
    return MAX_ROWS'(1) << idx;
  endfunction
endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: user-side write/swap/brightness inputs and scan outputs of the matrix scanner
interface led_matrix_scanner_if import led_matrix_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int BRIGHT_W = BRIGHT_W_DEF
);
  logic wr_en;
  logic [$clog2(ROWS)-1:0] wr_row;
  logic [COLS-1:0] wr_data;
  logic swap_req;
  logic [BRIGHT_W-1:0] brightness;
  logic [ROWS-1:0] rows;
  logic [COLS-1:0] cols;
  logic frame_start;
  logic swap_pending;
  modport master (
    output wr_en, wr_row, wr_data, swap_req, brightness,
    input rows, cols, frame_start, swap_pending
  );
  modport slave (
    input wr_en, wr_row, wr_data, swap_req, brightness,
    output rows, cols, frame_start, swap_pending
  );
endinterface

// File: rtl/led_matrix_scan_timer.sv
// led_matrix_scan_timer: dwell counter and row index with row-wrap and frame-end flags
module led_matrix_scan_timer import led_matrix_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int DIV_W = DIV_W_DEF,
  localparam int RW = $clog2(ROWS)
) (
  input  logic clk,
  input  logic reset_n,
  output logic [RW-1:0] row,
  output logic [DIV_W-1:0] cnt,
  output logic row_wrap,
  output logic frame_end
);
  logic [RW-1:0] r_row;
  logic [DIV_W-1:0] r_cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_cnt <= '0;
      r_row <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (row_wrap) r_row <= (r_row == RW'(ROWS - 1)) ? '0 : r_row + 1'b1;
    end
  assign row = r_row;
  assign cnt = r_cnt;
  assign row_wrap = &r_cnt;
  assign frame_end = row_wrap && (r_row == RW'(ROWS - 1));
endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: double-buffered row-scanned LED matrix driver with blanking and PWM
module led_matrix_scanner import led_matrix_pkg::*; #(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter int DIV_W = DIV_W_DEF,
  parameter int BRIGHT_W = BRIGHT_W_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input logic clk,
  input logic reset_n,
  led_matrix_scanner_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  logic [RW-1:0] w_row;
  logic [DIV_W-1:0] w_cnt;
  logic w_row_wrap, w_frame_end, w_blank, w_lit, w_wr_ok, w_swap;
  logic [COLS-1:0] w_front;
  logic [COLS-1:0] r_buf0 [ROWS];
  logic [COLS-1:0] r_buf1 [ROWS];
  logic r_fsel, r_pending, r_frame_start;
  logic [ROWS-1:0] r_rows;
  logic [COLS-1:0] r_cols;
  led_matrix_scan_timer #(.ROWS(ROWS), .DIV_W(DIV_W)) u_timer (
    .clk(clk),
    .reset_n(reset_n),
    .row(w_row),
    .cnt(w_cnt),
    .row_wrap(w_row_wrap),
    .frame_end(w_frame_end)
  );
  assign w_blank = 32'(w_cnt) < BLANK;
  assign w_lit = w_cnt[DIV_W-1 -: BRIGHT_W] < bus.brightness;
  assign w_front = r_fsel ? r_buf1[w_row] : r_buf0[w_row];
  assign w_wr_ok = bus.wr_en && (32'(bus.wr_row) < ROWS);
  assign w_swap = w_row_wrap && w_frame_end && (r_pending || bus.swap_req);
  // writes use the pre-swap select so a same-edge write lands in the buffer about to be shown
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_fsel <= 1'b0;
      r_pending <= 1'b0;
      r_rows <= '0;
      r_cols <= '0;
      r_frame_start <= 1'b0;
      for (int i = 0; i < ROWS; i++) begin
        r_buf0[i] <= '0;
        r_buf1[i] <= '0;
      end
    end else begin
      r_rows <= w_blank ? '0 : ROWS'(one_hot_row(ROW_IDX_W'(w_row)));
      r_cols <= (!w_blank && w_lit) ? w_front : '0;
      r_frame_start <= (w_row == '0) && (w_cnt == '0);
      if (w_wr_ok && r_fsel) r_buf0[bus.wr_row] <= bus.wr_data;
      if (w_wr_ok && !r_fsel) r_buf1[bus.wr_row] <= bus.wr_data;
      r_fsel <= r_fsel ^ w_swap;
      r_pending <= !w_swap && (r_pending || bus.swap_req);
    end
  assign bus.rows = r_rows;
  assign bus.cols = r_cols;
  assign bus.frame_start = r_frame_start;
  assign bus.swap_pending = r_pending;
endmodule
